// File: rtl/tinyalu_if.sv
// Command/response bundle for tinyalu_param: start/op/operands toward the ALU,
// ready/done/result back to the host driver.
interface tinyalu_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, op, A, B,
    input  ready, done, result
  );

  modport slave (
    input  start, op, A, B,
    output ready, done, result
  );
endinterface

// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU: single-cycle add/and/xor(/sub), multi-cycle unsigned multiply.
// Optional macro TINYALU_SUB_EN enables op 5 as a single-cycle subtract with borrow.
module tinyalu_param #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  tinyalu_if.slave bus
);

  typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

  localparam logic [2:0]         OP_MUL    = 3'd4;
  localparam bit                 MUL_MULTI = (MUL_LAT > 1);
  localparam int                 CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0]   CNT_INIT  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               done_q, done_nxt;
  logic [2*WIDTH-1:0] result_q, result_nxt;
  logic               ld_ops;
  logic [WIDTH-1:0]   a_p0, b_p0;

  // Every op result is zero-extended to 2*WIDTH; unknown opcodes yield zero.
  function automatic logic [2*WIDTH-1:0] alu_eval(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] res;
    wide = '0;
    res  = '0;
    case (op)
      3'd1: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = {{(WIDTH-1){1'b0}}, wide};
      end
      3'd2: res = {{WIDTH{1'b0}}, a & b};
      3'd3: res = {{WIDTH{1'b0}}, a ^ b};
      3'd4: res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`ifdef TINYALU_SUB_EN
      3'd5: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = {{(WIDTH-1){1'b0}}, wide};
      end
`endif
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    result_nxt = result_q;
    ld_ops     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (MUL_MULTI && (bus.op == OP_MUL)) begin
            state_nxt = MUL_BUSY;
            cnt_nxt   = CNT_INIT;
            ld_ops    = 1'b1;
          end else begin
            done_nxt   = 1'b1;
            result_nxt = alu_eval(bus.op, bus.A, bus.B);
          end
        end
      end
      MUL_BUSY: begin
        // Finishing on the edge that leaves count 1 puts done in cycle t+MUL_LAT.
        if (cnt == CNT_LAST) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          done_nxt   = 1'b1;
          result_nxt = alu_eval(OP_MUL, a_p0, b_p0);
        end else begin
          cnt_nxt = cnt - CNT_LAST;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      done_q   <= done_nxt;
      result_q <= result_nxt;
    end
  end

  // Stage p0: multiply operands captured at accept, held while busy.
  always_ff @(posedge clk) begin
    if (ld_ops) begin
      a_p0 <= bus.A;
      b_p0 <= bus.B;
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
